// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host-written instruction words in a FIFO
// and issues them one at a time to the processor over a valid/ready handshake.
// Free-run, single-step and halt-marker control; status for host readback.
module instr_issue_queue #(
  parameter int unsigned             DEPTH_LOG2  = 4,
  parameter int unsigned             INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE = 16'hFFFF
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   push_valid,
  input  logic [INSTR_WIDTH-1:0] push_data,
  output logic                   push_ready,
  input  logic                   flush,
  input  logic                   run_en,
  input  logic                   step,
  input  logic                   resume,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_data,
  input  logic                   instr_ready,
  output logic [DEPTH_LOG2:0]    fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   halted,
  output logic [15:0]            issued_count
);

  localparam int unsigned             DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]     C_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0]   C_PINC = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t                  r_state;
  logic [INSTR_WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_overflow;
  logic                    r_instr_valid;
  logic [INSTR_WIDTH-1:0]  r_instr_data;
  logic [15:0]             r_issued;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic [INSTR_WIDTH-1:0]  w_head;
  logic                    w_head_halt;
  logic                    w_permit;
  logic                    w_slot;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_halt_pop;
  logic                    w_handshake;

  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = push_valid && !w_full && !flush;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_halt = (w_head == HALT_OPCODE);
  assign w_permit    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_slot      = !r_instr_valid || instr_ready;
  // A pop either loads the head into the output register or discards a halt marker.
  assign w_pop       = w_slot && !w_empty && w_permit && !flush;
  assign w_load      = w_pop && !w_head_halt;
  assign w_halt_pop  = w_pop && w_head_halt;
  assign w_handshake = r_instr_valid && instr_ready;

  // FIFO storage write; contents need no reset since pointers/count gate all reads
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PINC;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PINC;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (push_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Issue control FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_en)    r_state <= ST_RUN;
          else if (step) r_state <= ST_STEP;
        end
        ST_RUN: begin
          if (w_halt_pop)   r_state <= ST_HALTED;
          else if (!run_en) r_state <= ST_IDLE;
        end
        ST_STEP: begin
          if (w_halt_pop)  r_state <= ST_HALTED;
          else if (w_load) r_state <= ST_IDLE;
        end
        ST_HALTED: begin
          if (resume) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load head when slot frees, clear on handshake, hold otherwise
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
    end else if (flush) begin
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr_valid <= 1'b1;
      r_instr_data  <= w_head;
    end else if (w_handshake) begin
      r_instr_valid <= 1'b0;
    end
  end

  // Completed-handshake counter; survives flush, wraps naturally
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)   r_issued <= '0;
    else if (w_handshake) r_issued <= r_issued + 16'd1;
  end

  assign push_ready   = !w_full;
  assign instr_valid  = r_instr_valid;
  assign instr_data   = r_instr_data;
  assign fifo_count   = r_count;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign overflow     = r_overflow;
  assign halted       = (r_state == ST_HALTED);
  assign issued_count = r_issued;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: scoreboard of expected issued
// words, checked by a handshake monitor, plus directed status checks.
module tb_instr_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic        flush;
  logic        run_en;
  logic        step;
  logic        resume;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        instr_ready;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        halted;
  logic [15:0] issued_count;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [15:0] sb[$];
  logic [15:0] exp_word;

  instr_issue_queue #(
    .DEPTH_LOG2  (4),
    .INSTR_WIDTH (16),
    .HALT_OPCODE (16'hFFFF)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .flush         (flush),
    .run_en        (run_en),
    .step          (step),
    .resume        (resume),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_ready   (instr_ready),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .halted        (halted),
    .issued_count  (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] w, input bit expect_issue);
    push_valid = 1'b1;
    push_data  = w;
    if (expect_issue) sb.push_back(w);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   instr_valid,  1'b0);
    check({tag, "_data"},    instr_data,   16'h0);
    check({tag, "_count"},   fifo_count,   5'd0);
    check({tag, "_empty"},   fifo_empty,   1'b1);
    check({tag, "_full"},    fifo_full,    1'b0);
    check({tag, "_pready"},  push_ready,   1'b1);
    check({tag, "_ovf"},     overflow,     1'b0);
    check({tag, "_halted"},  halted,       1'b0);
    check({tag, "_issued"},  issued_count, 16'h0);
  endtask

  // Handshake monitor: each accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      check("issue_pending", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        exp_word = sb.pop_front();
        check("issue_word", instr_data, exp_word);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    push_valid = 1'b0;
    push_data = '0;
    flush = 1'b0;
    run_en = 1'b0;
    step = 1'b0;
    resume = 1'b0;
    instr_ready = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single word in RUN, visible one cycle after its push edge
    run_en = 1'b1;
    instr_ready = 1'b1;
    tick();
    push(16'h1234, 1'b1);
    check("t1_not_yet", instr_valid, 1'b0);
    tick();
    check("t1_valid", instr_valid, 1'b1);
    check("t1_data", instr_data, 16'h1234);
    tick();
    check("t1_issued", issued_count, 16'd1);
    check("t1_drained", instr_valid, 1'b0);

    // 2: fill to full, overflow attempt, flush
    run_en = 1'b0;
    tick();
    for (int unsigned i = 0; i < 16; i++) push(16'h0100 + 16'(i), 1'b0);
    check("t2_count16", fifo_count, 5'd16);
    check("t2_full", fifo_full, 1'b1);
    check("t2_pready", push_ready, 1'b0);
    check("t2_no_ovf_yet", overflow, 1'b0);
    push(16'hDEAD, 1'b0);
    check("t2_ovf", overflow, 1'b1);
    check("t2_count_hold", fifo_count, 5'd16);
    check("t2_no_issue", instr_valid, 1'b0);
    do_flush();
    check("t2_flush_count", fifo_count, 5'd0);
    check("t2_flush_ovf", overflow, 1'b0);
    check("t2_flush_empty", fifo_empty, 1'b1);

    // 3: two single steps issue A then B only
    push(16'h000A, 1'b1);
    push(16'h000B, 1'b1);
    push(16'h000C, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(3);
    check("t3_after_A_count", fifo_count, 5'd2);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(3);
    check("t3_count", fifo_count, 5'd1);
    tick(3);
    check("t3_count_idle", fifo_count, 5'd1);
    check("t3_valid", instr_valid, 1'b0);
    check("t3_issued", issued_count, 16'd3);
    check("t3_sb_empty", sb.size(), 0);
    do_flush();

    // 4: halt marker stops issue, resume continues
    push(16'h0001, 1'b1);
    push(16'hFFFF, 1'b0);
    push(16'h0002, 1'b1);
    run_en = 1'b1;
    tick(6);
    check("t4_halted", halted, 1'b1);
    check("t4_count", fifo_count, 5'd1);
    check("t4_issued", issued_count, 16'd4);
    check("t4_valid", instr_valid, 1'b0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("t4_resumed", halted, 1'b0);
    tick(5);
    check("t4_issued2", issued_count, 16'd5);
    check("t4_count0", fifo_count, 5'd0);
    check("t4_sb_empty", sb.size(), 0);

    // 5: output held stable under backpressure after run_en drops
    instr_ready = 1'b0;
    push(16'hBEEF, 1'b1);
    push(16'hCAFE, 1'b0);
    run_en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check("t5_hold_valid", instr_valid, 1'b1);
      check("t5_hold_data", instr_data, 16'hBEEF);
      check("t5_fifo", fifo_count, 5'd1);
      tick();
    end
    instr_ready = 1'b1;
    tick(3);
    check("t5_valid_done", instr_valid, 1'b0);
    check("t5_fifo_after", fifo_count, 5'd1);
    check("t5_issued", issued_count, 16'd6);
    do_flush();

    // 6: asynchronous reset mid-stream
    instr_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push(16'h0500 + 16'(i), 1'b0);
    run_en = 1'b1;
    tick(3);
    check("t6_pre_valid", instr_valid, 1'b1);
    check("t6_pre_count", fifo_count, 5'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    run_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
